// File: rtl/dsd_pkg.sv
// Shared definitions for the DSD lab serial datapath blocks.
package dsd_pkg;

  // Default operand width for the serial arithmetic blocks.
  localparam int N_DEFAULT = 4;

  // Control state of the serial subtractor; 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle of the serial subtractor.
//
// Handshake: the requester raises start together with A/B; the request is
// accepted on the first rising edge seen in IDLE (busy rises from that edge).
// While busy or during the done cycle start is ignored and operands are not
// re-sampled. done is a single-cycle pulse; Diff/Bout are valid from that
// edge and hold until the next operation completes.
interface serial_subtractor_if #(
  parameter int N = dsd_pkg::N_DEFAULT
) ();
  import dsd_pkg::*;

  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         busy;
  logic         done;
  logic [N-1:0] Diff;
  logic         Bout;
  state_t       dbg_state;

  modport master (
    output start, A, B,
    input  busy, done, Diff, Bout, dbg_state
  );

  modport slave (
    input  start, A, B,
    output busy, done, Diff, Bout, dbg_state
  );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: D = A - B - Bin, Bout set when the bit borrows.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  // Difference and borrow-out of a single bit position.
  always_comb begin
    D    = A ^ B ^ Bin;
    Bout = (~A & B) | (~(A ^ B) & Bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: Diff = A - B, LSB first, one bit per clock,
// reusing one full-subtractor cell and a borrow flip-flop.
module serial_subtractor
  import dsd_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input logic             clk,
  input logic             rst,
  serial_subtractor_if.slave bus
);

  localparam int CW = $clog2(N);

  state_t       state;
  logic [N-1:0] sa;
  logic [N-1:0] sb;
  logic [N-1:0] res;
  logic         borrow;
  logic [CW-1:0] count;
  logic         busy_q;
  logic         done_q;
  logic [N-1:0] diff_q;
  logic         bout_q;

  logic         bit_d;
  logic         bit_bo;

  // The single shared cell works on the current LSBs and the stored borrow.
  full_subtractor u_cell (
    .A    (sa[0]),
    .B    (sb[0]),
    .Bin  (borrow),
    .D    (bit_d),
    .Bout (bit_bo)
  );

  // Control FSM plus datapath registers; every output is registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      borrow <= 1'b0;
      count  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            sa     <= bus.A;
            sb     <= bus.B;
            borrow <= 1'b0;
            count  <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          // Result fills from the top so bit 0 lands in place after N shifts.
          res    <= {bit_d, res[N-1:1]};
          borrow <= bit_bo;
          count  <= count + 1'b1;
          if (count == CW'(N - 1)) begin
            diff_q <= {bit_d, res[N-1:1]};
            bout_q <= bit_bo;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.Diff      = diff_q;
  assign bus.Bout      = bout_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor and its full_subtractor cell.
module tb_serial_subtractor;
  import dsd_pkg::*;

  localparam int N = 4;

  logic clk;
  logic rst;

  serial_subtractor_if #(.N(N)) bus ();

  serial_subtractor #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Standalone cell under test.
  logic fa, fb, fbin, fd, fbo;
  full_subtractor u_fs (
    .A    (fa),
    .B    (fb),
    .Bin  (fbin),
    .D    (fd),
    .Bout (fbo)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [N:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // {borrow, diff} is simply A - B in N+1-bit two's complement.
  function automatic logic [N:0] ref_sub(input logic [N-1:0] a, input logic [N-1:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  // ---------------- scoreboard compare ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_diff", 32'(bus.Diff), 0);
    check("rst_bout", 32'(bus.Bout), 0);
    check("rst_state", 32'(bus.dbg_state), 32'(IDLE));
    rst = 1'b0;
  endtask

  // One complete operation; operands are scrambled after acceptance and a
  // stray start is pulsed mid-run, neither of which may disturb the result.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input string tag, input bit verbose);
    logic [N:0] exp;
    int cycles;
    @(negedge clk);
    bus.start = 1'b1;
    bus.A = a;
    bus.B = b;
    exp_q.push_back(ref_sub(a, b));
    @(negedge clk);
    bus.start = 1'b0;
    bus.A = N'($urandom);
    bus.B = N'($urandom);
    check({tag, "_busy"}, 32'(bus.busy), 1);
    cycles = 1;
    while (bus.done !== 1'b1 && cycles < N + 4) begin
      @(negedge clk);
      cycles++;
      if (cycles == 2) bus.start = 1'b1;
      if (cycles == 3) bus.start = 1'b0;
    end
    bus.start = 1'b0;
    exp = exp_q.pop_front();
    check({tag, "_latency"}, 32'(cycles), 32'(N + 1));
    check({tag, "_diff"}, 32'(bus.Diff), 32'(exp[N-1:0]));
    check({tag, "_bout"}, 32'(bus.Bout), 32'(exp[N]));
    check({tag, "_busy_off"}, 32'(bus.busy), 0);
    if (verbose)
      $display("op A=%0d B=%0d Diff=%0d Bout=%0b done=%0b", a, b, bus.Diff, bus.Bout, bus.done);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(bus.done), 0);
    check({tag, "_idle"}, 32'(bus.dbg_state), 32'(IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cycles;
    int v;
    bit saw_done;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    fa = 1'b0; fb = 1'b0; fbin = 1'b0;

    // Cell truth table, expectations from integer arithmetic.
    for (int i = 0; i < 8; i++) begin
      fa = i[2]; fb = i[1]; fbin = i[0];
      #1;
      v = int'(fa) - int'(fb) - int'(fbin);
      check($sformatf("fs_d_%0d", i), 32'(fd), 32'(v & 1));
      check($sformatf("fs_bo_%0d", i), 32'(fbo), (v < 0) ? 1 : 0);
    end

    apply_reset();

    // Basic and borrow cases.
    run_op(4'd5, 4'd3, "basic", 1'b0);
    check("basic_val", 32'(bus.Diff), 32'h2);
    run_op(4'd3, 4'd5, "borrow1", 1'b0);
    check("borrow1_val", 32'({bus.Bout, bus.Diff}), 32'h1E);
    run_op(4'd0, 4'd1, "borrow2", 1'b0);
    check("borrow2_val", 32'({bus.Bout, bus.Diff}), 32'h1F);

    // Idle holds the last result.
    repeat (3) @(negedge clk);
    check("idle_hold", 32'({bus.Bout, bus.Diff}), 32'h1F);

    // Reset in the middle of an operation.
    @(negedge clk);
    bus.start = 1'b1; bus.A = 4'd5; bus.B = 4'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_state_run", 32'(bus.dbg_state), 32'(RUN));
    rst = 1'b1;
    #1;
    check("mid_busy", 32'(bus.busy), 0);
    check("mid_done", 32'(bus.done), 0);
    check("mid_diff", 32'(bus.Diff), 0);
    check("mid_bout", 32'(bus.Bout), 0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < N + 3; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    check("mid_no_done", 32'(saw_done), 0);
    run_op(4'd8, 4'd8, "after_rst", 1'b0);

    // Corners.
    run_op(4'hF, 4'hF, "c_ff", 1'b0);
    run_op(4'hF, 4'h0, "c_f0", 1'b0);
    run_op(4'h0, 4'h0, "c_00", 1'b0);

    // start held high: operands changed during RUN, back-to-back spacing.
    @(negedge clk);
    bus.start = 1'b1; bus.A = 4'd9; bus.B = 4'd2;
    @(negedge clk);
    bus.A = 4'd1; bus.B = 4'd1;
    cycles = 1;
    while (bus.done !== 1'b1 && cycles < N + 4) begin
      @(negedge clk);
      cycles++;
    end
    check("hs_latency", 32'(cycles), 32'(N + 1));
    check("hs_diff1", 32'(bus.Diff), 32'd7);
    check("hs_bout1", 32'(bus.Bout), 0);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (bus.done !== 1'b1 && cycles < 2 * N + 4);
    check("hs_spacing", 32'(cycles), 32'(N + 2));
    check("hs_diff2", 32'(bus.Diff), 32'd0);
    bus.start = 1'b0;
    @(negedge clk);
    check("hs_done_off", 32'(bus.done), 0);
    check("hs_idle", 32'(bus.dbg_state), 32'(IDLE));

    // Random operands.
    for (int i = 0; i < 40; i++)
      run_op(N'($urandom_range(0, 15)), N'($urandom_range(0, 15)), "rand", 1'b0);

    // Exhaustive sweep.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run_op(N'(a), N'(b), "exh", 1'b1);

    check("sb_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
